// File: rtl/vector_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_loader_if                                                         |
// | Command/UART-byte inputs and vector-A memory write port of the loader.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface vector_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [1:0]            command;
  logic [7:0]            byte_received;
  logic                  rx_data_ready;
  logic                  coprocessor_busy;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_din;
  logic                  load_done;
  logic                  load_error;
  logic [ADDR_WIDTH:0]   bytes_loaded;

  // Decoder / UART / memory side
  modport master (
    output command, byte_received, rx_data_ready,
    input  coprocessor_busy, mem_we, mem_addr, mem_din,
    input  load_done, load_error, bytes_loaded
  );

  // Loader side
  modport slave (
    input  command, byte_received, rx_data_ready,
    output coprocessor_busy, mem_we, mem_addr, mem_din,
    output load_done, load_error, bytes_loaded
  );
endinterface
`default_nettype wire

// File: rtl/vector_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_loader                                                            |
// | Streams N_ELEMENTS UART bytes into vector-A memory on a READ_A command.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vector_loader #(
  parameter int N_ELEMENTS     = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic          clk,
  input  logic          rst,
  vector_loader_if.slave bus
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
  localparam logic [1:0] c_st_error = 2'd3;

  localparam logic [1:0] c_cmd_read_a = 2'd1;

  localparam int                    c_tmr_w    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_tmr_w-1:0]    c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]   c_n_total  = (ADDR_WIDTH+1)'(N_ELEMENTS);

  logic [1:0]            r_state;
  logic [c_tmr_w-1:0]    r_tmr;
  logic [ADDR_WIDTH:0]   r_bytes;
  logic                  r_busy;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_din;
  logic                  r_load_done;
  logic                  r_load_error;
  logic [ADDR_WIDTH:0]   w_bytes_next;

  assign w_bytes_next = r_bytes + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_tmr        <= '0;
      r_bytes      <= '0;
      r_busy       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        // A strobe coinciding with the command is its terminator: not stored.
        c_st_idle: begin
          if (bus.command == c_cmd_read_a) begin
            r_state      <= c_st_load;
            r_busy       <= 1'b1;
            r_bytes      <= '0;
            r_load_error <= 1'b0;
            r_tmr        <= '0;
          end
        end
        c_st_load: begin
          if (bus.rx_data_ready) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_bytes[ADDR_WIDTH-1:0];
            r_mem_din  <= bus.byte_received;
            r_bytes    <= w_bytes_next;
            r_tmr      <= '0;
            if (w_bytes_next == c_n_total) begin
              r_state     <= c_st_done;
              r_busy      <= 1'b0;
              r_load_done <= 1'b1;
            end
          end else if (r_tmr == c_tmr_last) begin
            r_state      <= c_st_error;
            r_busy       <= 1'b0;
            r_load_error <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.coprocessor_busy = r_busy;
  assign bus.mem_we           = r_mem_we;
  assign bus.mem_addr         = r_mem_addr;
  assign bus.mem_din          = r_mem_din;
  assign bus.load_done        = r_load_done;
  assign bus.load_error       = r_load_error;
  assign bus.bytes_loaded     = r_bytes;

endmodule
`default_nettype wire

// File: tb/tb_vector_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vector_loader                                                         |
// | Directed self-checking bench: N_ELEMENTS=4, TIMEOUT_CYCLES=8.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vector_loader;

  localparam int c_n  = 4;
  localparam int c_aw = 2;
  localparam int c_to = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;
  int   n_dones  = 0;

  vector_loader_if #(.ADDR_WIDTH(c_aw)) bus ();

  vector_loader #(
    .N_ELEMENTS    (c_n),
    .ADDR_WIDTH    (c_aw),
    .TIMEOUT_CYCLES(c_to)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we)    n_writes++;
    if (bus.load_done) n_dones++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic rdy, input logic [7:0] b);
    bus.command       = cmd;
    bus.rx_data_ready = rdy;
    bus.byte_received = b;
  endtask

  task automatic check_write(input string tag, input int addr, input logic [7:0] data);
    check({tag, "_we"},   {31'd0, bus.mem_we}, 32'd1);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
    check({tag, "_din"},  32'(bus.mem_din), 32'(data));
  endtask

  logic [7:0] nominal [4];

  initial begin
    nominal[0] = 8'h11; nominal[1] = 8'h22; nominal[2] = 8'h33; nominal[3] = 8'h44;
    drive(2'd0, 1'b0, 8'h00);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",  {31'd0, bus.coprocessor_busy}, 32'd0);
    check("rst_we",    {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr",  32'(bus.mem_addr), 32'd0);
    check("rst_din",   32'(bus.mem_din), 32'd0);
    check("rst_done",  {31'd0, bus.load_done}, 32'd0);
    check("rst_err",   {31'd0, bus.load_error}, 32'd0);
    check("rst_bytes", 32'(bus.bytes_loaded), 32'd0);

    // Stray traffic in IDLE, including command=2
    drive(2'd0, 1'b1, 8'h5A); tick();
    check("stray_we", {31'd0, bus.mem_we}, 32'd0);
    drive(2'd2, 1'b1, 8'h5B); tick();
    check("stray2_we",   {31'd0, bus.mem_we}, 32'd0);
    check("stray2_busy", {31'd0, bus.coprocessor_busy}, 32'd0);

    // Nominal load with a terminator strobe alongside the command
    drive(2'd1, 1'b1, 8'hEE); tick();
    check("term_we",    {31'd0, bus.mem_we}, 32'd0);
    check("term_busy",  {31'd0, bus.coprocessor_busy}, 32'd1);
    check("term_bytes", 32'(bus.bytes_loaded), 32'd0);
    drive(2'd0, 1'b0, 8'h00); tick();
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 1'b1, nominal[i]); tick();
      check_write("nom", i, nominal[i]);
      check("nom_bytes", 32'(bus.bytes_loaded), 32'(i + 1));
      check("nom_done",  {31'd0, bus.load_done}, (i == 3) ? 32'd1 : 32'd0);
      check("nom_busy",  {31'd0, bus.coprocessor_busy}, (i == 3) ? 32'd0 : 32'd1);
      drive(2'd0, 1'b0, 8'h00);
      if (i < 3) begin
        tick();
        check("nom_gap_we", {31'd0, bus.mem_we}, 32'd0);
        tick();
      end
    end
    tick();
    check("nom_done_clr", {31'd0, bus.load_done}, 32'd0);
    check("nom_bytes_hold", 32'(bus.bytes_loaded), 32'd4);

    // Back-to-back bytes, then a strobe and command during DONE
    drive(2'd1, 1'b0, 8'h00); tick();
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 1'b1, 8'hA0 + 8'(i)); tick();
      check_write("b2b", i, 8'hA0 + 8'(i));
    end
    check("b2b_done", {31'd0, bus.load_done}, 32'd1);
    drive(2'd1, 1'b1, 8'hFF); tick();
    check("done_byte_we", {31'd0, bus.mem_we}, 32'd0);
    check("done_cmd_busy", {31'd0, bus.coprocessor_busy}, 32'd0);
    drive(2'd0, 1'b0, 8'h00); tick();
    check("done_cmd_busy2", {31'd0, bus.coprocessor_busy}, 32'd0);

    // Timeout after two bytes
    drive(2'd1, 1'b0, 8'h00); tick();
    drive(2'd0, 1'b1, 8'hC0); tick();
    drive(2'd0, 1'b1, 8'hC1); tick();
    check_write("to_b1", 1, 8'hC1);
    drive(2'd0, 1'b0, 8'h00);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("to_wait_err", {31'd0, bus.load_error}, 32'd0);
      check("to_wait_busy", {31'd0, bus.coprocessor_busy}, 32'd1);
    end
    tick();
    check("to_err",   {31'd0, bus.load_error}, 32'd1);
    check("to_busy",  {31'd0, bus.coprocessor_busy}, 32'd0);
    check("to_bytes", 32'(bus.bytes_loaded), 32'd2);
    drive(2'd1, 1'b1, 8'hD0); tick();
    check("err_byte_we",  {31'd0, bus.mem_we}, 32'd0);
    check("err_cmd_busy", {31'd0, bus.coprocessor_busy}, 32'd0);
    drive(2'd0, 1'b1, 8'hD1); tick();
    check("idle_byte_we", {31'd0, bus.mem_we}, 32'd0);
    check("err_sticky",   {31'd0, bus.load_error}, 32'd1);

    // New command clears the error; a byte on the expiry cycle wins
    drive(2'd1, 1'b0, 8'h00); tick();
    check("restart_err",   {31'd0, bus.load_error}, 32'd0);
    check("restart_busy",  {31'd0, bus.coprocessor_busy}, 32'd1);
    check("restart_bytes", 32'(bus.bytes_loaded), 32'd0);
    drive(2'd0, 1'b0, 8'h00);
    for (int k = 0; k < 7; k++) tick();
    drive(2'd0, 1'b1, 8'hE0); tick();
    check_write("win", 0, 8'hE0);
    check("win_err",  {31'd0, bus.load_error}, 32'd0);
    check("win_busy", {31'd0, bus.coprocessor_busy}, 32'd1);
    drive(2'd0, 1'b1, 8'hE1); tick();
    check_write("win_b1", 1, 8'hE1);

    // Reset mid-load
    drive(2'd0, 1'b0, 8'h00);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy",  {31'd0, bus.coprocessor_busy}, 32'd0);
    check("mid_rst_we",    {31'd0, bus.mem_we}, 32'd0);
    check("mid_rst_addr",  32'(bus.mem_addr), 32'd0);
    check("mid_rst_din",   32'(bus.mem_din), 32'd0);
    check("mid_rst_bytes", 32'(bus.bytes_loaded), 32'd0);
    drive(2'd0, 1'b1, 8'hF0); tick();
    check("post_rst_we", {31'd0, bus.mem_we}, 32'd0);
    drive(2'd0, 1'b1, 8'hF1); tick();
    check("post_rst_we2", {31'd0, bus.mem_we}, 32'd0);
    drive(2'd1, 1'b0, 8'h00); tick();
    drive(2'd0, 1'b1, 8'hF2); tick();
    check_write("post_rst_load", 0, 8'hF2);
    drive(2'd0, 1'b0, 8'h00); tick(); tick();

    check("total_writes", 32'(n_writes), 32'd13);
    check("total_dones",  32'(n_dones), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
